// File: rtl/bus_ram_bank.sv
// bus_ram_bank: bus-mapped RAM window of DEPTH words at BASE_ADDR on the
// 16-bit local bus, with a control word at BASE_ADDR+DEPTH that launches a
// hardware clear sweep (every word <= INIT_VAL), edge-qualified writes and a
// wrapping count of accepted RAM writes.
// Optional feature: define BUS_RAM_PARITY_EN to store an even-parity bit per
// word and report mismatches on reads through the sticky parity_err output.
// Without the macro no parity is stored and parity_err is tied low.

module bus_ram_bank #(
    parameter logic [15:0]       BASE_ADDR = 16'd20,
    parameter int                DEPTH     = 8,
    parameter int                DATA_W    = 16,
    parameter logic [DATA_W-1:0] INIT_VAL  = DATA_W'(32'd99)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       addr_bus,
    input  logic [DATA_W-1:0] data_bus,
    input  logic              rw,
    input  logic              data_strobe,
    output logic              address_valid,
    output logic [DATA_W-1:0] data_bus_o,
    output logic              busy,
    output logic [15:0]       wr_count,
    output logic              parity_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so the offset can also represent the control word.
    localparam int OFF_W = IDX_W + 1;

    localparam logic [16:0]      LO_C       = {1'b0, BASE_ADDR};
    localparam logic [16:0]      HI_C       = {1'b0, BASE_ADDR} + 17'(DEPTH);
    localparam logic [OFF_W-1:0] CTRL_OFF_C = OFF_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX_C = IDX_W'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_par(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Registered state
    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              address_valid_q, address_valid_d;
    logic [OFF_W-1:0]  addr_q, addr_d;
    logic              strobe_dly_q, strobe_dly_d;
    logic [DATA_W-1:0] data_bus_o_q, data_bus_o_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Combinational helpers
    logic              hit_s;
    logic [OFF_W-1:0]  off_s;
    logic              busy_s;
    logic              stb_rise_s;
    logic              is_ram_s;
    logic              is_ctrl_s;
    logic [IDX_W-1:0]  addr_idx_s;
    logic              ram_wr_s;
    logic              ctrl_clr_s;
    logic              rd_ram_s;
    logic              rd_ctrl_s;
    logic              mem_we_s;
    logic [IDX_W-1:0]  mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;

`ifdef BUS_RAM_PARITY_EN
    logic [DEPTH-1:0]  par_q;
    logic              parity_err_q, parity_err_d;
`endif

    // Address decode for the next-cycle address_valid / offset registers.
    always_comb begin
        hit_s = ({1'b0, addr_bus} >= LO_C) && ({1'b0, addr_bus} <= HI_C);
        off_s = OFF_W'(addr_bus - BASE_ADDR);
        address_valid_d = hit_s;
        if (hit_s) begin
            addr_d = off_s;
        end else begin
            addr_d = '0;
        end
        strobe_dly_d = data_strobe;
    end

    // Access qualification from the registered decode and the strobe edge.
    always_comb begin
        busy_s     = (state_q == ST_CLEAR);
        stb_rise_s = data_strobe & ~strobe_dly_q;
        is_ram_s   = (addr_q < CTRL_OFF_C);
        is_ctrl_s  = (addr_q == CTRL_OFF_C);
        addr_idx_s = addr_q[IDX_W-1:0];
        ram_wr_s   = rw & address_valid_q & stb_rise_s & is_ram_s & ~busy_s;
        ctrl_clr_s = rw & address_valid_q & stb_rise_s & is_ctrl_s
                     & data_bus[0] & ~busy_s;
        rd_ram_s   = ~rw & address_valid_q & is_ram_s;
        rd_ctrl_s  = ~rw & address_valid_q & is_ctrl_s;
    end

    // Clear-sweep FSM, RAM write port and write counter.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_count_d  = wr_count_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = idx_q;
                mem_wdata_s = INIT_VAL;
                if (idx_q == LAST_IDX_C) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_IDLE: begin
                if (ram_wr_s) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = addr_idx_s;
                    mem_wdata_s = data_bus;
                    wr_count_d  = wr_count_q + 16'd1;
                end else if (ctrl_clr_s) begin
                    state_d    = ST_CLEAR;
                    idx_d      = '0;
                    wr_count_d = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    // Read data mux: RAM word (0 while sweeping), control status, or 0.
    always_comb begin
        data_bus_o_d = '0;
        if (rd_ram_s) begin
            if (busy_s) begin
                data_bus_o_d = '0;
            end else begin
                data_bus_o_d = mem_q[addr_idx_s];
            end
        end else if (rd_ctrl_s) begin
            data_bus_o_d[0] = busy_s;
        end else begin
            data_bus_o_d = '0;
        end
    end

`ifdef BUS_RAM_PARITY_EN
    // Sticky parity error: set by a mismatching RAM read, cleared by a clear command.
    always_comb begin
        parity_err_d = parity_err_q;
        if (ctrl_clr_s) begin
            parity_err_d = 1'b0;
        end else if (rd_ram_s && !busy_s
                     && (even_par(mem_q[addr_idx_s]) != par_q[addr_idx_s])) begin
            parity_err_d = 1'b1;
        end else begin
            parity_err_d = parity_err_q;
        end
    end

    // Parity error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // RAM storage; contents are defined by the sweep that follows every reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
`ifdef BUS_RAM_PARITY_EN
            par_q[mem_waddr_s] <= even_par(mem_wdata_s);
`endif
        end
    end

    // Control and output registers; reset launches a fresh sweep from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_CLEAR;
            idx_q           <= '0;
            address_valid_q <= 1'b0;
            addr_q          <= '0;
            strobe_dly_q    <= 1'b0;
            data_bus_o_q    <= '0;
            wr_count_q      <= 16'd0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            address_valid_q <= address_valid_d;
            addr_q          <= addr_d;
            strobe_dly_q    <= strobe_dly_d;
            data_bus_o_q    <= data_bus_o_d;
            wr_count_q      <= wr_count_d;
        end
    end

    assign address_valid = address_valid_q;
    assign data_bus_o    = data_bus_o_q;
    assign busy          = busy_s;
    assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_bus_ram_bank.sv
// Self-checking bench for bus_ram_bank (default parameters). The reference
// model keeps the RAM as an int array, the write count as an int and the
// clear sweep as a count of remaining busy cycles.

module tb_bus_ram_bank;

    localparam int DEPTH = 8;
    localparam int BASE  = 20;
    localparam int INIT  = 99;
    localparam int CTRL  = BASE + DEPTH;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr_bus;
    logic [15:0] data_bus;
    logic        rw;
    logic        data_strobe;
    logic        address_valid;
    logic [15:0] data_bus_o;
    logic        busy;
    logic [15:0] wr_count;
    logic        parity_err;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int model_mem [DEPTH];
    int model_cnt;
    int sweep_left;
    int exp_perr;
`ifdef BUS_RAM_PARITY_EN
    logic [DEPTH-1:0] par_snap;
`endif

    bus_ram_bank dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr_bus     (addr_bus),
        .data_bus     (data_bus),
        .rw           (rw),
        .data_strobe  (data_strobe),
        .address_valid(address_valid),
        .data_bus_o   (data_bus_o),
        .busy         (busy),
        .wr_count     (wr_count),
        .parity_err   (parity_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int in_win(input int a);
        return ((a >= BASE) && (a <= CTRL)) ? 1 : 0;
    endfunction

    function automatic int busy_now();
        return (sweep_left > 0) ? 1 : 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT;
        model_cnt = 0;
        exp_perr  = 0;
    endtask

    // One clock; sample 1 time unit after the edge; the sweep advances a word.
    task automatic tick();
        @(posedge clk);
        #1;
        if (sweep_left > 0) sweep_left--;
    endtask

    task automatic rd(input int a);
        int exp;
        int b;
        addr_bus = 16'(a); rw = 1'b0; data_strobe = 1'b0; data_bus = 16'h0000;
        tick();
        check("rd_valid", address_valid, in_win(a));
        b = busy_now();
        if (in_win(a) == 0)  exp = 0;
        else if (a == CTRL)  exp = b;
        else if (b != 0)     exp = 0;
        else                 exp = model_mem[a - BASE];
        tick();
        check("rd_data", data_bus_o, exp);
        check("rd_busy", busy, busy_now());
        check("rd_perr", parity_err, exp_perr);
    endtask

    task automatic wr(input int a, input int d);
        int b;
        addr_bus = 16'(a); rw = 1'b1; data_bus = 16'(d); data_strobe = 1'b0;
        tick();
        check("wr_valid", address_valid, in_win(a));
        data_strobe = 1'b1;
        b = busy_now();
        tick();
        if ((b == 0) && (in_win(a) != 0)) begin
            if (a < CTRL) begin
                model_mem[a - BASE] = d & 32'hFFFF;
                model_cnt = (model_cnt + 1) & 32'hFFFF;
            end else if ((d & 1) != 0) begin
                model_clear();
                sweep_left = DEPTH;
            end
        end
        check("wr_busy", busy, busy_now());
        check("wr_count", wr_count, model_cnt);
        data_strobe = 1'b0;
        tick();
    endtask

    task automatic wait_idle();
        for (int i = 0; (i < DEPTH + 2) && (sweep_left > 0); i++) tick();
        check("idle_busy", busy, 0);
    endtask

    task automatic sweep_check(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            check(tag, busy, busy_now());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; addr_bus = 16'h0000; data_bus = 16'h0000;
        rw = 1'b0; data_strobe = 1'b0;
        model_clear();
        sweep_left = DEPTH;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", address_valid, 0);
        check("rst_data", data_bus_o, 0);
        check("rst_count", wr_count, 0);
        check("rst_busy", busy, 1);
        check("rst_perr", parity_err, 0);

        // Sweep after reset release: busy for exactly DEPTH cycles.
        rst_n = 1'b1;
        sweep_left = DEPTH;
        sweep_check("sweep_busy");
        for (int w = 0; w < DEPTH; w++) rd(BASE + w);
        check("sweep_count", wr_count, 0);

        // Single write / read back.
        wr(22, 32'hA5A5);
        rd(22);
        check("wr1_count", wr_count, 1);

        // Held strobe: only the first value is stored, counted once.
        addr_bus = 16'(BASE); rw = 1'b1; data_bus = 16'h1000; data_strobe = 1'b0;
        tick();
        data_strobe = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data_bus = 16'(32'h1000 + k * 32'h1111);
            tick();
            if (k == 0) begin
                model_mem[0] = 32'h1000;
                model_cnt++;
            end
        end
        data_strobe = 1'b0;
        tick();
        check("held_count", wr_count, model_cnt);
        rd(BASE);

        // Decode bounds.
        rd(BASE - 1);
        rd(CTRL + 1);
        rd(CTRL);

        // Clear during use: second CTRL write and a RAM write mid-sweep are dropped.
        for (int w = 0; w < DEPTH; w++) wr(BASE + w, int'($urandom_range(0, 65535)));
        for (int w = 0; w < DEPTH; w++) rd(BASE + w);
        wr(CTRL, 1);
        rd(CTRL);
        wr(CTRL, 1);
        wr(23, 32'h1234);
        wait_idle();
        for (int w = 0; w < DEPTH; w++) rd(BASE + w);
        check("clr_count", wr_count, 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op < 4)       rd(int'($urandom_range(BASE - 2, CTRL + 2)));
            else if (op < 8)  wr(int'($urandom_range(BASE - 2, CTRL + 2)), int'($urandom_range(0, 65535)));
            else if (op == 8) wr(CTRL, int'($urandom_range(0, 3)));
            else              repeat (int'($urandom_range(1, 4))) tick();
        end
        wait_idle();
        for (int w = 0; w < DEPTH; w++) rd(BASE + w);

        // Reset in the middle of a sweep restarts it from word 0.
        wr(21, 32'h0BEE);
        wr(CTRL, 1);
        tick();
        rst_n = 1'b0;
        #2;
        check("mid_rst_busy", busy, 1);
        check("mid_rst_count", wr_count, 0);
        check("mid_rst_data", data_bus_o, 0);
        rst_n = 1'b1;
        model_clear();
        sweep_left = DEPTH;
        sweep_check("resweep_busy");
        for (int w = 0; w < DEPTH; w++) rd(BASE + w);

`ifdef BUS_RAM_PARITY_EN
        // Corrupt the stored parity of word 3 and read it.
        wr(23, 32'h00F1);
        par_snap = dut.par_q;
        force dut.par_q = par_snap ^ 8'h08;
        exp_perr = 1;
        rd(23);
        release dut.par_q;
        rd(20);
        rd(23);
        wr(CTRL, 1);
        check("perr_clr", parity_err, exp_perr);
        wait_idle();
        rd(23);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
